// File: rtl/f_ifu.sv
// Fetch-stage instruction unit: drives one request/response access per PC and
// holds the fetched word until the pipeline advances.
module f_ifu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NPC,
  input  logic        Stall,
  input  logic        MDStall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        FetchBusy,
  output logic        AdEL,
  output logic        FetchErr
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] buf_r;
  logic [7:0]  cnt_r;
  logic        adel_r;
  logic        ferr_r;
  logic        req_r;
  logic        valid_r;

  logic        advance_s;
  logic        pc_ok_s;
  logic        npc_ok_s;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
  endfunction

  assign advance_s = (state_r == HOLD) && !Stall && !MDStall;
  assign pc_ok_s   = addr_legal(pc_r);
  assign npc_ok_s  = addr_legal(NPC);

  // Fetch FSM; req_r/valid_r are precomputed for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= REQ;
      pc_r    <= 32'h0000_3000;
      buf_r   <= 32'h0000_0000;
      cnt_r   <= 8'd0;
      adel_r  <= 1'b0;
      ferr_r  <= 1'b0;
      req_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        REQ: begin
          if (!pc_ok_s) begin
            state_r <= HOLD;
            buf_r   <= 32'h0000_0000;
            adel_r  <= 1'b1;
            valid_r <= 1'b1;
            req_r   <= 1'b0;
          end else if (req_r && imem_gnt) begin
            state_r <= WAIT;
            cnt_r   <= 8'd0;
            req_r   <= 1'b0;
          end else begin
            // Covers the first cycle after reset, when no request is out yet.
            req_r   <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_r <= HOLD;
            buf_r   <= imem_rdata;
            valid_r <= 1'b1;
          end else if (cnt_r >= 8'd254) begin
            // Counter reaches 255 this cycle with no response: give up.
            state_r <= HOLD;
            buf_r   <= 32'h0000_0000;
            ferr_r  <= 1'b1;
            valid_r <= 1'b1;
            cnt_r   <= 8'd255;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
          end
        end
        HOLD: begin
          if (advance_s) begin
            state_r <= REQ;
            pc_r    <= NPC;
            buf_r   <= 32'h0000_0000;
            adel_r  <= 1'b0;
            ferr_r  <= 1'b0;
            valid_r <= 1'b0;
            req_r   <= npc_ok_s;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= REQ;
          buf_r   <= 32'h0000_0000;
          adel_r  <= 1'b0;
          ferr_r  <= 1'b0;
          valid_r <= 1'b0;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = pc_r;
  assign PC         = pc_r;
  assign Instr      = buf_r;
  assign InstrValid = valid_r;
  assign FetchBusy  = (state_r != HOLD);
  assign AdEL       = adel_r;
  assign FetchErr   = ferr_r;

endmodule

// File: tb/tb_f_ifu.sv
// Directed bench for f_ifu: a scripted instruction memory plus a scoreboard of
// expected HOLD contents (PC, Instr, AdEL, FetchErr).
module tb_f_ifu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] npc;
  logic        npc_auto = 1'b0;
  logic [31:0] npc_man = 32'h0;
  logic        stall = 1'b0;
  logic        mdstall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_busy;
  logic        adel;
  logic        fetch_err;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
    logic        ferr;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   waited;

  f_ifu dut (
    .clk(clk), .reset(reset), .NPC(npc), .Stall(stall), .MDStall(mdstall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PC(pc), .Instr(instr),
    .InstrValid(instr_valid), .FetchBusy(fetch_busy), .AdEL(adel), .FetchErr(fetch_err)
  );

  always #5 clk = ~clk;
  assign npc = npc_auto ? pc + 32'd4 : npc_man;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] d, input logic a, input logic f);
    exp_t e;
    e.pc = p; e.instr = d; e.adel = a; e.ferr = f;
    sb.push_back(e);
  endtask

  // Compare the HOLD contents against the oldest scoreboard entry.
  task automatic sb_check(input string tag);
    exp_t e;
    chk1({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk1({tag, "_valid"}, instr_valid, 1'b1);
      chk1({tag, "_busy"}, fetch_busy, 1'b0);
      chk({tag, "_pc"}, pc, e.pc);
      chk({tag, "_instr"}, instr, e.instr);
      chk1({tag, "_adel"}, adel, e.adel);
      chk1({tag, "_ferr"}, fetch_err, e.ferr);
    end
  endtask

  // Memory model: wait for a request, grant after gdly cycles, answer rdly cycles later.
  task automatic serve(input int gdly, input int rdly, input logic [31:0] d);
    logic [31:0] a;
    waited = 0;
    while (!imem_req && waited < 40) begin
      step();
      waited++;
    end
    chk1("req_seen", imem_req, 1'b1);
    a = imem_addr;
    for (int i = 0; i < gdly; i++) begin
      step();
      chk1("req_held", imem_req, 1'b1);
      chk("addr_stable", imem_addr, a);
    end
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk1("wait_no_req", imem_req, 1'b0);
    for (int i = 0; i < rdly; i++) step();
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_pc", pc, 32'h0000_3000);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_busy", fetch_busy, 1'b1);
    chk1("rst_adel", adel, 1'b0);
    chk1("rst_ferr", fetch_err, 1'b0);
    #2 reset = 1'b0;
    step();
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0000_3000);

    // Back-to-back single-cycle memory
    npc_auto = 1'b1;
    push(32'h3000, 32'h1111_0000, 1'b0, 1'b0);
    serve(0, 0, 32'h1111_0000);
    sb_check("f0");
    push(32'h3004, 32'h2222_0004, 1'b0, 1'b0);
    serve(0, 0, 32'h2222_0004);
    chk("cadence", waited, 32'd1);
    sb_check("f1");

    // Stall in HOLD
    stall = 1'b1;
    npc_auto = 1'b0;
    npc_man = 32'h3004;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pc", pc, 32'h3004);
      chk("stall_instr", instr, 32'h2222_0004);
      chk1("stall_valid", instr_valid, 1'b1);
      chk1("stall_req", imem_req, 1'b0);
    end
    stall = 1'b0;
    npc_auto = 1'b1;
    step();
    chk("adv_pc", pc, 32'h3008);
    chk1("adv_req", imem_req, 1'b1);
    push(32'h3008, 32'h3333_0008, 1'b0, 1'b0);
    serve(0, 0, 32'h3333_0008);
    chk("adv_wait", waited, 32'd0);
    sb_check("f2");

    // Misaligned NPC
    npc_auto = 1'b0;
    npc_man = 32'h3002;
    step();
    chk1("adel_noreq", imem_req, 1'b0);
    chk("adel_pc_req", pc, 32'h3002);
    push(32'h3002, 32'h0, 1'b1, 1'b0);
    step();
    chk1("adel_noreq2", imem_req, 1'b0);
    sb_check("adel");
    npc_man = 32'h300C;
    step();
    chk1("adel_clr", adel, 1'b0);
    chk1("adel_req", imem_req, 1'b1);

    // Response timeout
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    for (int i = 0; i < 254; i++) step();
    chk1("to_busy", fetch_busy, 1'b1);
    chk1("to_notvalid", instr_valid, 1'b0);
    push(32'h300C, 32'h0, 1'b0, 1'b1);
    step();
    sb_check("timeout");
    stall = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    chk("late_instr", instr, 32'h0);
    chk1("late_ferr", fetch_err, 1'b1);
    stall = 1'b0;
    npc_man = 32'h3010;
    step();
    chk1("ferr_clr", fetch_err, 1'b0);

    // rvalid on the cycle the counter would reach 255 wins
    push(32'h3010, 32'h5555_0010, 1'b0, 1'b0);
    serve(0, 254, 32'h5555_0010);
    sb_check("edge");

    // Reset in WAIT
    step();
    chk("rw_pc", pc, 32'h3010);
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    chk1("rw_inwait", fetch_busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("rw_pc_rst", pc, 32'h3000);
    chk1("rw_req_rst", imem_req, 1'b0);
    step();
    #2 reset = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    chk1("rw_req", imem_req, 1'b1);
    chk("rw_addr", imem_addr, 32'h3000);
    chk1("rw_valid", instr_valid, 1'b0);
    step();
    chk1("rw_ignored", fetch_busy, 1'b1);
    chk("rw_instr", instr, 32'h0);

    // Delayed grant under MDStall
    npc_auto = 1'b1;
    mdstall = 1'b1;
    push(32'h3000, 32'h6666_3000, 1'b0, 1'b0);
    serve(3, 0, 32'h6666_3000);
    sb_check("md");
    step();
    chk("md_hold_pc", pc, 32'h3000);
    chk1("md_hold_valid", instr_valid, 1'b1);
    mdstall = 1'b0;
    step();
    chk("md_adv_pc", pc, 32'h3004);
    chk1("md_adv_req", imem_req, 1'b1);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/f_ifu.md
F_IFU -- requirements
Module: f_ifu

Interface
REQ-001 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port NPC  in  32  next-PC from the fetch-stage NPC logic.
REQ-004 SHALL have port Stall  in  1  hazard-unit freeze of the fetch stage.
REQ-005 SHALL have port MDStall  in  1  mult/div busy freeze of the fetch stage.
REQ-006 SHALL have port imem_req  out  1  instruction-memory request valid.
REQ-007 SHALL have port imem_addr  out  32  request word address, equal to PC.
REQ-008 SHALL have port imem_gnt  in  1  memory accepted the request this cycle.
REQ-009 SHALL have port imem_rvalid  in  1  read data valid.
REQ-010 SHALL have port imem_rdata  in  32  instruction word.
REQ-011 SHALL have port PC  out  32  address of the instruction currently held.
REQ-012 SHALL have port Instr  out  32  fetched instruction; 0x00000000 (nop) when InstrValid=0.
REQ-013 SHALL have port InstrValid  out  1  Instr is valid for the D stage.
REQ-014 SHALL have port FetchBusy  out  1  fetch not complete; hazard unit ORs this into its stall.
REQ-015 SHALL have port AdEL  out  1  PC misaligned or outside the instruction window.
REQ-016 SHALL have port FetchErr  out  1  memory response timeout.

Function
REQ-017 SHALL implement FSM states REQ, WAIT, HOLD.
REQ-018 SHALL define advance = (state==HOLD) && !Stall && !MDStall.
REQ-019 In REQ: imem_req=1, imem_addr=PC; on imem_gnt go to WAIT and clear the wait counter, else stay in REQ.
REQ-020 In WAIT: imem_req=0; on imem_rvalid latch imem_rdata into the instruction buffer and go to HOLD.
REQ-021 In HOLD: InstrValid=1, Instr=buffer; on advance load PC<=NPC, clear AdEL/FetchErr, go to REQ; otherwise hold every register.
REQ-022 FetchBusy SHALL equal (state!=HOLD), combinationally.
REQ-023 imem_rvalid SHALL be ignored in REQ and HOLD; imem_gnt SHALL be ignored in WAIT and HOLD.
REQ-024 Minimum fetch latency: gnt in cycle N, rvalid in cycle N+1, InstrValid=1 in cycle N+2.
REQ-025 Legal window: PC[1:0]==0 and 0x00003000 <= PC <= 0x00006FFC.
REQ-026 If in REQ with PC outside the legal window: no request (imem_req=0); next cycle go to HOLD with buffer=0 and AdEL=1.
REQ-027 The wait counter SHALL be 8 bits wide, increment each WAIT cycle without rvalid, and saturate at 255.
REQ-028 When the counter reaches 255 in WAIT without rvalid: go to HOLD with buffer=0 and FetchErr=1.
REQ-029 rvalid in the same cycle the counter reaches 255 SHALL take priority: normal capture, FetchErr=0.
REQ-030 PC SHALL change only on advance; Stall/MDStall in REQ or WAIT SHALL NOT abort the outstanding access.
REQ-031 AdEL and FetchErr SHALL be asserted only in HOLD and are mutually exclusive.

Reset
REQ-032 While reset=1 (asynchronous):
- PC=0x00003000, state=REQ, buffer=0, counter=0, AdEL=0, FetchErr=0.
- imem_req=0, InstrValid=0, Instr=0, FetchBusy=1.
REQ-033 Reset asserted mid-access SHALL discard the outstanding access; any rvalid arriving after reset release while in REQ is ignored per REQ-023.
REQ-034 First request SHALL be issued in the first cycle after reset deasserts: imem_req=1, imem_addr=0x00003000.

Verification
REQ-035 Single-cycle memory (gnt when requested, rvalid the next cycle), Stall=MDStall=0, NPC=PC+4 -> one instruction every 3 cycles, PCs 0x3000, 0x3004, 0x3008.
REQ-036 HOLD at PC=0x3004 with Stall=1 for 4 cycles, NPC=0x3004 -> PC, Instr and InstrValid=1 stable; no imem_req; advance on the first cycle after Stall drops.
REQ-037 NPC=0x00003002 on advance -> no imem_req; next cycle HOLD with AdEL=1, Instr=0, PC=0x3002.
REQ-038 gnt then no rvalid for 255 cycles -> FetchErr=1, Instr=0, InstrValid=1; a late rvalid in HOLD is ignored.
REQ-039 reset pulse while in WAIT at PC=0x3010, rvalid 1 cycle after release -> PC=0x3000, rvalid ignored, new request to 0x3000.
REQ-040 gnt delayed 3 cycles with MDStall=1 throughout -> imem_req held high with a stable address; capture completes and HOLD is entered despite MDStall.
